// File: rtl/registers_tx_block_pkg.sv
// Shared types and helpers for the register readback transmitter.
package registers_tx_block_pkg;

  // Serializer states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4
  } tx_state_e;

  localparam int DEF_REG_ADDR_WIDTH = 8;
  localparam int DEF_REG_DATA_WIDTH = 16;
  localparam int DEF_TX_DATA_WIDTH  = 8;
  localparam int DEF_NUM_REGS       = 16;

  // Frame length in bytes: header, count, then per entry one address byte
  // plus the data bytes of that entry.
  function automatic int frame_len(input int num_regs, input int bytes_per_reg);
    return 2 + num_regs * (1 + bytes_per_reg);
  endfunction

endpackage

// File: rtl/registers_tx_block_if.sv
// Register write bus snoop, readback request and tx_protocol source signals.
//
// Handshake: the source drives tx_data/tx_eof with tx_rdy=1; a byte moves in
// any cycle where tx_rdy=1 and tx_ack=1. While tx_rdy=1 and tx_ack=0 the
// source holds tx_data and tx_eof unchanged. tx_ack with tx_rdy=0 means
// nothing. register_rdy is a one-cycle write strobe, rqst_regs a one-cycle
// request pulse.
interface registers_tx_block_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TX_DATA_WIDTH  = 8
);
  logic [REG_ADDR_WIDTH-1:0] register_addr;
  logic [REG_DATA_WIDTH-1:0] register_data;
  logic                      register_rdy;
  logic                      rqst_regs;
  logic [TX_DATA_WIDTH-1:0]  tx_data;
  logic                      tx_rdy;
  logic                      tx_eof;
  logic                      tx_ack;
  logic                      busy;

  // Host / register bus side.
  modport master (
    output register_addr, register_data, register_rdy, rqst_regs, tx_ack,
    input  tx_data, tx_rdy, tx_eof, busy
  );

  // Readback block side.
  modport slave (
    input  register_addr, register_data, register_rdy, rqst_regs, tx_ack,
    output tx_data, tx_rdy, tx_eof, busy
  );
endinterface

// File: rtl/registers_tx_block_register_shadow.sv
// Shadow copy of a contiguous register window plus a frozen snapshot of it.
// The snapshot is what the serializer reads, so later writes never disturb a
// frame already in flight.
module registers_tx_block_register_shadow #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BASE = 0,
  parameter int IW        = 5,
  parameter logic [NUM_REGS*DW-1:0] DEFAULTS = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          snap_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o
);
  logic [DW-1:0] shadow_q [NUM_REGS];
  logic [DW-1:0] shadow_d [NUM_REGS];
  logic [DW-1:0] snap_q   [NUM_REGS];
  logic [DW-1:0] snap_d   [NUM_REGS];

  // Address decode per entry; out-of-window addresses match no entry.
  // The snapshot takes the post-write value so a same-cycle write is included.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en_i && (wr_addr_i == AW'(ADDR_BASE + i))) begin
        shadow_d[i] = wr_data_i;
      end
      snap_d[i] = snap_i ? shadow_d[i] : snap_q[i];
    end
  end

  // Shadow and snapshot storage, both reloaded from the reset image.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= DEFAULTS[i*DW +: DW];
        snap_q[i]   <= DEFAULTS[i*DW +: DW];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        snap_q[i]   <= snap_d[i];
      end
    end
  end

  // Indexed snapshot read; an index past the window reads zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_i == IW'(i)) begin
        rd_data_o = snap_q[i];
      end
    end
  end

endmodule

// File: rtl/registers_tx_block.sv
// Register readback transmitter: snoops the register write bus into a shadow,
// and on request serializes a snapshot of the window as a byte frame:
// HEADER, NUM_REGS, then per entry {address, data bytes MSB first}.
module registers_tx_block
  import registers_tx_block_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter int TX_DATA_WIDTH  = DEF_TX_DATA_WIDTH,
  parameter int ADDR_BASE      = 0,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter logic [NUM_REGS*REG_DATA_WIDTH-1:0] DEFAULTS = '0,
  parameter logic [TX_DATA_WIDTH-1:0]           HEADER   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  registers_tx_block_if.slave  bus,
  output tx_state_e            state_o
);
  localparam int BPR = REG_DATA_WIDTH / TX_DATA_WIDTH;
  localparam int IW  = $clog2(NUM_REGS) + 1;
  localparam int BSW = (BPR > 1) ? $clog2(BPR) : 1;

  tx_state_e state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [BSW-1:0] bsel_q, bsel_d;

  logic                      snap;
  logic [REG_DATA_WIDTH-1:0] rd_data;
  logic [REG_DATA_WIDTH-1:0] rd_shifted;
  logic [TX_DATA_WIDTH-1:0]  tx_data;
  logic                      tx_rdy;
  logic                      tx_eof;
  logic                      xfer;
  logic                      last_byte;
  logic                      last_entry;

  registers_tx_block_register_shadow #(
    .AW        (REG_ADDR_WIDTH),
    .DW        (REG_DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_BASE (ADDR_BASE),
    .IW        (IW),
    .DEFAULTS  (DEFAULTS)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bus.register_rdy),
    .wr_addr_i (bus.register_addr),
    .wr_data_i (bus.register_data),
    .snap_i    (snap),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data)
  );

  assign last_byte  = (bsel_q == BSW'(BPR - 1));
  assign last_entry = (idx_q == IW'(NUM_REGS - 1));
  assign xfer       = tx_rdy & bus.tx_ack;
  // Byte bsel_q of the entry, counted from the most significant end.
  assign rd_shifted = rd_data >> (TX_DATA_WIDTH * (BPR - 1 - int'(bsel_q)));

  // FSM state and frame position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      bsel_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bsel_q  <= bsel_d;
    end
  end

  // Next state and the byte presented in the current state. Outputs depend
  // only on registered state and the frozen snapshot, so they hold during stalls.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bsel_d  = bsel_q;
    snap    = 1'b0;
    tx_data = '0;
    tx_rdy  = 1'b0;
    tx_eof  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idx_d  = '0;
        bsel_d = '0;
        if (bus.rqst_regs) begin
          snap    = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_rdy  = 1'b1;
        tx_data = HEADER;
        if (xfer) state_d = ST_CNT;
      end
      ST_CNT: begin
        tx_rdy  = 1'b1;
        tx_data = TX_DATA_WIDTH'(NUM_REGS);
        if (xfer) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        tx_rdy  = 1'b1;
        tx_data = TX_DATA_WIDTH'(ADDR_BASE + int'(idx_q));
        if (xfer) begin
          bsel_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_rdy  = 1'b1;
        tx_data = rd_shifted[TX_DATA_WIDTH-1:0];
        tx_eof  = last_byte & last_entry;
        if (xfer) begin
          if (!last_byte) begin
            bsel_d = bsel_q + 1'b1;
          end else if (last_entry) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.tx_data = tx_data;
  assign bus.tx_rdy  = tx_rdy;
  assign bus.tx_eof  = tx_eof;
  assign bus.busy    = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_registers_tx_block.sv
// Bench for registers_tx_block at default parameters (16 x 16-bit window at 0).
module tb_registers_tx_block;
  import registers_tx_block_pkg::*;

  localparam int NREG = 16;

  typedef struct {
    logic       ack;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic       exp_eof;
    logic       exp_busy;
  } vec_t;

  logic      clk = 1'b0;
  logic      rst;
  tx_state_e dbg_state;

  registers_tx_block_if #(.REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(16), .TX_DATA_WIDTH(8)) bus();

  registers_tx_block dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int         total_cnt = 0;
  int         pass_cnt  = 0;
  logic [15:0] model_q [NREG];
  logic [7:0] exp_q [$];
  vec_t       vecs [51];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic model_write(input logic [7:0] a, input logic [15:0] d);
    if (a < NREG) model_q[a[3:0]] = d;
  endtask

  function automatic void build_frame();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(NREG));
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back(8'(i));
      exp_q.push_back(model_q[i][15:8]);
      exp_q.push_back(model_q[i][7:0]);
    end
  endfunction

  // Driver: one register write strobe.
  task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.register_addr = a;
    bus.register_data = d;
    bus.register_rdy  = 1'b1;
    model_write(a, d);
    @(negedge clk);
    bus.register_rdy  = 1'b0;
  endtask

  // Driver: request pulse, optionally with a write in the same cycle.
  task automatic start_req(input bit with_wr, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.rqst_regs = 1'b1;
    if (with_wr) begin
      bus.register_addr = a;
      bus.register_data = d;
      bus.register_rdy  = 1'b1;
      model_write(a, d);
    end
    build_frame();
  endtask

  // Receiver: consumes bytes against exp_q, checks stall stability, can
  // inject a write / request after a given byte count, and optionally stops
  // early. For a full frame, checks the idle cycle after and may re-request there.
  task automatic recv_frame(input bit rand_ack, input int stop_after,
                            input int wr_at, input logic [7:0] wa, input logic [15:0] wd,
                            input int rq_at, input bit chain_rq);
    int got = 0;
    int cyc = 0;
    bit done = 0;
    bit wr_done = 0;
    bit rq_done = 0;
    bit stalled = 0;
    logic [7:0] held_data = '0;
    logic held_eof = 1'b0;
    logic a;
    logic [7:0] e;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.rqst_regs    = 1'b0;
      bus.register_rdy = 1'b0;
      if (got == wr_at && !wr_done) begin
        wr_done = 1;
        bus.register_addr = wa;
        bus.register_data = wd;
        bus.register_rdy  = 1'b1;
        model_write(wa, wd);
      end
      if (got == rq_at && !rq_done) begin
        rq_done = 1;
        bus.rqst_regs = 1'b1;
      end
      if (stalled) begin
        check("stall_data", bus.tx_data, held_data);
        check("stall_eof", bus.tx_eof, held_eof);
        check("stall_rdy", bus.tx_rdy, 1'b1);
      end
      a = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.tx_ack = a;
      stalled = 0;
      if (bus.tx_rdy) begin
        if (!a) begin
          stalled = 1;
          held_data = bus.tx_data;
          held_eof = bus.tx_eof;
        end else if (exp_q.size() == 0) begin
          fail_now("extra_byte");
          done = 1;
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", bus.tx_data, e);
          check("frame_eof", bus.tx_eof, exp_q.size() == 0);
          check("frame_busy", bus.busy, 1'b1);
          got++;
          if (exp_q.size() == 0 || got == stop_after) done = 1;
        end
      end
    end
    if (!done) fail_now("frame_timeout");
    if (stop_after == 0) begin
      @(negedge clk);
      bus.register_rdy = 1'b0;
      bus.rqst_regs = chain_rq;
      check("end_rdy", bus.tx_rdy, 1'b0);
      check("end_busy", bus.busy, 1'b0);
      check("end_state", dbg_state, ST_IDLE);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    bus.register_addr = '0;
    bus.register_data = '0;
    bus.register_rdy  = 1'b0;
    bus.rqst_regs     = 1'b0;
    bus.tx_ack        = 1'b0;
    for (int i = 0; i < NREG; i++) model_q[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_rdy", bus.tx_rdy, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_tx_eof", bus.tx_eof, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);

    // Defaults dump vectors: A5, 10, then {i, 00, 00} per entry, idle after.
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1};
    for (int i = 0; i < NREG; i++) begin
      vecs[2 + 3*i] = '{1'b1, 1'b1, 8'(i), 1'b0, 1'b1};
      vecs[3 + 3*i] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[4 + 3*i] = '{1'b1, 1'b1, 8'h00, (i == NREG - 1), 1'b1};
    end
    vecs[50] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    bus.rqst_regs = 1'b1;
    bus.tx_ack    = 1'b1;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      bus.rqst_regs = 1'b0;
      bus.tx_ack    = vecs[k].ack;
      check($sformatf("vec%0d_rdy", k), bus.tx_rdy, vecs[k].exp_rdy);
      check($sformatf("vec%0d_data", k), bus.tx_data, vecs[k].exp_data);
      check($sformatf("vec%0d_eof", k), bus.tx_eof, vecs[k].exp_eof);
      check($sformatf("vec%0d_busy", k), bus.busy, vecs[k].exp_busy);
    end

    // Write then dump: in-window and out-of-window writes.
    write_reg(8'd3, 16'h1234);
    write_reg(8'd20, 16'hFFFF);
    start_req(1'b0, 8'd0, 16'h0);
    recv_frame(1'b0, 0, -1, 8'd0, 16'h0, -1, 1'b0);

    // Backpressure: same frame with random ack.
    start_req(1'b0, 8'd0, 16'h0);
    recv_frame(1'b1, 0, -1, 8'd0, 16'h0, -1, 1'b0);

    // Same-cycle write is captured; mid-frame write and request are not.
    start_req(1'b1, 8'd5, 16'hBEEF);
    recv_frame(1'b0, 0, 15, 8'd6, 16'h0F0F, 25, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("dropped_rq_rdy", bus.tx_rdy, 1'b0);
      check("dropped_rq_busy", bus.busy, 1'b0);
    end

    // Later request shows 0F0F; a request in the IDLE re-entry cycle is taken.
    start_req(1'b0, 8'd0, 16'h0);
    recv_frame(1'b1, 0, -1, 8'd0, 16'h0, -1, 1'b1);
    build_frame();
    recv_frame(1'b0, 0, -1, 8'd0, 16'h0, -1, 1'b0);

    // Reset mid-frame after byte 10.
    start_req(1'b0, 8'd0, 16'h0);
    recv_frame(1'b0, 10, -1, 8'd0, 16'h0, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rdy", bus.tx_rdy, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_eof", bus.tx_eof, 1'b0);
    for (int i = 0; i < NREG; i++) model_q[i] = '0;
    start_req(1'b0, 8'd0, 16'h0);
    recv_frame(1'b0, 0, -1, 8'd0, 16'h0, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
